fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the `fifo` block among `NUM_REQ` producers. Each producer offers data on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `BURST_LEN` beats and forwards the granted stream to the FIFO's `w_en`/`w_data`. FIFO `full` backpressure is honoured, so no write is ever issued into a full FIFO.

## Interface
- `NUM_REQ`, default 4: number of producers, ≥2.
- `DATA_WIDTH`, default 32: word width; must match the FIFO.
- `BURST_LEN`, default 4: maximum beats per grant, ≥1.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `grant_id`. Derived; do not override.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  NUM_REQ  producer i has a word on its slice of `req_data`.
- `req_data`  in  NUM_REQ*DATA_WIDTH  flattened; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  producer i's word is accepted this cycle.
- `fifo_w_en`  out  1  to FIFO `w_en`.
- `fifo_w_data`  out  DATA_WIDTH  to FIFO `w_data`.
- `fifo_full`  in  1  from FIFO `full`.
- `grant_valid`  out  1  a producer currently holds the grant (registered).
- `grant_id`  out  ID_W  index of the granted producer (registered).

## Operation
- State machine with 2 states.
  - IDLE: no grant.
  - BUSY: grant held by `grant_id`.
- Registered state: `state`, `grant_id`, `beat_cnt` (width `$clog2(BURST_LEN+1)`), `last_id`.
- Round-robin search:
  - Starts at `(last_id+1) mod NUM_REQ` and wraps through all indices.
  - Picks the first i with `req_valid[i]`.
  - `last_id` is updated to the winner on every new grant.
- IDLE:
  - If any `req_valid`, load the winner into `grant_id`, clear `beat_cnt`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Transfer condition: `xfer = req_valid[grant_id] & !fifo_full`.
  - On `xfer`, `beat_cnt` increments.
- Grant release, evaluated in BUSY at the clock edge:
  - (a) `xfer` and `beat_cnt+1 == BURST_LEN`; or
  - (b) `!req_valid[grant_id]`.
- On release:
  - If any other producer is valid, re-grant directly to the round-robin winner (BUSY→BUSY, `beat_cnt` cleared).
  - Otherwise go to IDLE.
  - The releasing producer is eligible only after all others in round-robin order.
- `fifo_full` with valid held: the grant is held, `beat_cnt` is frozen, and the grant is never released for backpressure.
- Combinational outputs:
  - `req_ready[i] = (state==BUSY) & (grant_id==i) & !fifo_full`.
  - `fifo_w_en = xfer`.
  - `fifo_w_data` = granted producer's slice when `grant_valid`, else 0.
- Producer rule: once `req_valid` is raised, data is held stable until `req_ready`. Dropping valid between words ends the burst.
- Reset values:
  - IDLE, `grant_valid=0`, `grant_id=0`, `beat_cnt=0`, `last_id=NUM_REQ-1`, so producer 0 wins first.
  - All outputs are 0 during and immediately after reset.
- Reset mid-burst: the grant is dropped on the reset edge with no partial-write side effects. No write is issued while `rst` is high.

## Timing
- Arbitration latency: `req_valid` rising in IDLE in cycle N gives the grant and first possible `fifo_w_en` in cycle N+1.
- Burst handoff (release (a) with another producer waiting): zero bubble. The last beat of producer A is in cycle N, the first beat of producer B is in cycle N+1.
- Release (b) costs one idle write cycle: the cycle in which the granted valid was low.
- Throughput: one word per cycle while `!fifo_full` and the granted producer stays valid.
- `fifo_full` is used combinationally in the same cycle. The FIFO's `full` must reflect the post-write count of the previous edge, as the `fifo` block provides.
- A write and a FIFO read in the same cycle are legal. The arbiter only looks at `full`.

## Test plan
- **Reset:** hold `rst` 4 cycles with all `req_valid=1` → all outputs 0. The first cycle after release is still a grant cycle, and producer 0 writes in the next cycle.
- **Round-robin, no backpressure:** all 4 producers valid continuously, FIFO `DEPTH=64`, `BURST_LEN=4`, producer i sends i*100+k → FIFO order 0,1,2,3 bursts of 4 with no bubbles, then wraps back to 0. 32 words read back in exact order.
- **Backpressure:** force `fifo_full=1` for 3 cycles after beat 2 of producer 1 → `req_ready=0` and `fifo_w_en=0` for 3 cycles, `grant_id=1` and `beat_cnt=2` hold. Beats 3–4 follow, then the grant passes to 2.
- **Early release:** producer 2 drops valid after 2 beats while producer 3 is valid → one idle cycle, then producer 3 granted. Producer 2 is not re-granted before 3, 0 and 1.
- **Pointer wrap:** only producers 3 and 0 valid, start after `last_id=2` → order 3,0,3,0. Verify the search wraps from 3 to 0.
- **Reset mid-burst:** assert `rst` during beat 2 of producer 1 for 1 cycle → `fifo_w_en=0` that cycle and after. After reset, producer 0 wins if valid, and the FIFO holds only the words written before reset.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ valid/ready producers, honouring FIFO full.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  localparam int              CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  MAX_ID    = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  grant_id_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic [ID_W-1:0]  last_id, last_id_n;

  logic                  busy;
  logic                  cur_valid;
  logic                  xfer;
  logic                  release_grant;
  logic [NUM_REQ-1:0]    candidates;
  logic                  rr_found;
  logic [ID_W-1:0]       rr_winner;
  logic [ID_W-1:0]       rr_idx;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  assign busy          = (state == BUSY);
  assign cur_valid     = req_valid[grant_id];
  assign xfer          = busy & cur_valid & ~fifo_full;
  assign release_grant = busy & ((xfer & (beat_cnt == LAST_BEAT)) | ~cur_valid);

  // The current holder is excluded, so a releasing producer waits for everyone else.
  always_comb begin
    candidates = req_valid;
    if (busy) candidates[grant_id] = 1'b0;
  end

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = last_id;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = (rr_idx == MAX_ID) ? '0 : rr_idx + 1'b1;
      if (!rr_found && candidates[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_id_n = grant_id;
    beat_cnt_n = beat_cnt;
    last_id_n  = last_id;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_n    = BUSY;
          grant_id_n = rr_winner;
          last_id_n  = rr_winner;
          beat_cnt_n = '0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          beat_cnt_n = '0;
          if (rr_found) begin
            grant_id_n = rr_winner;
            last_id_n  = rr_winner;
          end else begin
            state_n = IDLE;
          end
        end else if (xfer) begin
          beat_cnt_n = beat_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      last_id  <= MAX_ID;
    end else begin
      state    <= state_n;
      grant_id <= grant_id_n;
      beat_cnt <= beat_cnt_n;
      last_id  <= last_id_n;
    end
  end

  // Reset gates the combinational outputs so nothing is written while rst is high.
  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
      assign data_arr[g]  = req_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[g] = busy & (grant_id == ID_W'(g)) & ~fifo_full & ~rst;
    end
  endgenerate

  assign grant_valid = busy;
  assign fifo_w_en   = xfer & ~rst;
  assign fifo_w_data = (busy & ~rst) ? data_arr[grant_id] : '0;

endmodule
`default_nettype wire
